// File: rtl/mem_wb_queue_if.sv
// Memory-to-writeback record type and the handshake bundle between the memory
// stage, the MEM/WB queue and the writeback stage.
package mem_wb_pkg;

  typedef struct packed {
    logic        valid;
    logic        skip;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] alu_out;
    logic [63:0] MemReadData;
  } memory_data_t;

endpackage

interface mem_wb_queue_if;

  mem_wb_pkg::memory_data_t dataM_nxt;
  logic                     stallM;
  logic                     in_ready;
  logic                     wb_ready;
  mem_wb_pkg::memory_data_t dataM;
  logic                     wb_valid;

  // Producer/consumer side (memory stage + writeback stage)
  modport master (
    output dataM_nxt, stallM, wb_ready,
    input  in_ready, dataM, wb_valid
  );

  // Queue side
  modport slave (
    input  dataM_nxt, stallM, wb_ready,
    output in_ready, dataM, wb_valid
  );

endinterface

// File: rtl/mem_wb_queue.sv
// Small FIFO between the memory and writeback stages. The head is presented
// from registered state only, so there is no input-to-output bypass.
module mem_wb_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_wb_queue_if.slave            bus,
  input  logic                     flushW,
  output logic [$clog2(DEPTH):0]   count,
  output logic [63:0]              retired
);
  import mem_wb_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [63:0]     r_retired;
  memory_data_t    r_mem [DEPTH];

  logic            w_in_ready;
  logic            w_wb_valid;
  logic            w_enq;
  logic            w_deq;

  assign w_in_ready = (r_state != ST_FULL);
  assign w_wb_valid = (r_state != ST_EMPTY);

  assign w_enq = bus.dataM_nxt.valid & ~bus.stallM & w_in_ready & ~flushW;
  assign w_deq = w_wb_valid & bus.wb_ready & ~flushW;

  // Occupancy next-state: flush wins, otherwise enqueue/dequeue adjust count
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (flushW) begin
      w_count_nxt = {CW{1'b0}};
    end else begin
      case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
    if (w_count_nxt == {CW{1'b0}}) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_count_nxt == CW'(DEPTH)) begin
      w_state_nxt = ST_FULL;
    end else begin
      w_state_nxt = ST_PARTIAL;
    end
  end

  // Occupancy state, pointers and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_EMPTY;
      r_count   <= {CW{1'b0}};
      r_rd_ptr  <= {PW{1'b0}};
      r_wr_ptr  <= {PW{1'b0}};
      r_retired <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (flushW) begin
        r_rd_ptr <= {PW{1'b0}};
        r_wr_ptr <= {PW{1'b0}};
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_deq) begin
          r_rd_ptr  <= r_rd_ptr + PW'(1);
          r_retired <= r_retired + 64'd1;
        end
      end
    end
  end

  // Entry storage carries no reset; it is never visible while empty
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= bus.dataM_nxt;
    end
  end

  // Head presentation
  always_comb begin
    bus.in_ready = w_in_ready;
    bus.wb_valid = w_wb_valid;
    if (w_wb_valid) begin
      bus.dataM = r_mem[r_rd_ptr];
    end else begin
      bus.dataM = '0;
    end
  end

  assign count   = r_count;
  assign retired = r_retired;

endmodule

// File: tb/tb_mem_wb_queue.sv
// Scoreboard bench for mem_wb_queue (DEPTH=2): directed enqueue/dequeue,
// stall, flush, full-queue and asynchronous-reset scenarios.
module tb_mem_wb_queue;
  import mem_wb_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flushW;
  logic [1:0]  count;
  logic [63:0] retired;

  mem_wb_queue_if bus();

  mem_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .flushW  (flushW),
    .count   (count),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  memory_data_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic memory_data_t mk(input logic [63:0] pc, input logic skip);
    memory_data_t d;
    d.valid       = 1'b1;
    d.skip        = skip;
    d.rd          = pc[6:2];
    d.pc          = pc;
    d.alu_out     = pc + 64'h0000_0000_0000_1000;
    d.MemReadData = pc ^ 64'hDEAD_BEEF_CAFE_F00D;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input memory_data_t d, input logic stall, input bit accept);
    bus.dataM_nxt = d;
    bus.stallM    = stall;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic idle_in();
    bus.dataM_nxt = '0;
    bus.stallM    = 1'b0;
  endtask

  // Monitor: every edge that will consume the head is checked against the scoreboard
  always @(negedge clk) begin
    memory_data_t e;
    if (reset && bus.wb_valid && bus.wb_ready && !flushW) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dequeue: got pc %h expected no entry", bus.dataM.pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.dataM !== e) begin
          n_fail++;
          $display("FAIL head_entry: got %h expected %h", bus.dataM, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    flushW        = 1'b0;
    bus.wb_ready  = 1'b0;
    bus.dataM_nxt = '0;
    bus.stallM    = 1'b0;
    #12;
    chk("rst_count",    64'(count), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_retired",  retired, 64'd0);
    chk("rst_dataM",    64'(bus.dataM.pc | bus.dataM.alu_out | 64'(bus.dataM.valid)), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // One-cycle latency through an empty queue
    offer(mk(64'h0000_0000_8000_0000, 1'b0), 1'b0, 1'b1);
    bus.wb_ready = 1'b1;
    chk("empty_no_bypass", 64'(bus.wb_valid), 64'd0);
    step();
    idle_in();
    chk("a_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("a_pc",       bus.dataM.pc, 64'h0000_0000_8000_0000);
    chk("a_count",    64'(count), 64'd1);
    step();
    chk("a_retired",  retired, 64'd1);
    chk("a_drained",  64'(count), 64'd0);
    chk("empty_dataM_zero", bus.dataM.MemReadData, 64'd0);

    // Fill to DEPTH, refuse a third entry, drain in order
    bus.wb_ready = 1'b0;
    offer(mk(64'h0000_0000_8000_0010, 1'b1), 1'b0, 1'b1);
    step();
    offer(mk(64'h0000_0000_8000_0020, 1'b0), 1'b0, 1'b1);
    step();
    idle_in();
    chk("full_count",    64'(count), 64'd2);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    offer(mk(64'h0000_0000_8000_0030, 1'b0), 1'b0, 1'b0);
    step();
    idle_in();
    chk("c_refused", 64'(count), 64'd2);
    bus.wb_ready = 1'b1;
    step();
    chk("drain1_count", 64'(count), 64'd1);
    step();
    chk("drain2_count", 64'(count), 64'd0);
    chk("drain_retired", retired, 64'd3);
    bus.wb_ready = 1'b0;

    // Stall holds entries out until the memory stage is ready
    offer(mk(64'h0000_0000_8000_0040, 1'b0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_count", 64'(count), 64'd0);
    end
    offer(mk(64'h0000_0000_8000_0040, 1'b0), 1'b0, 1'b1);
    step();
    idle_in();
    chk("unstall_count", 64'(count), 64'd1);

    // Flush beats a concurrent enqueue
    offer(mk(64'h0000_0000_8000_0050, 1'b0), 1'b0, 1'b0);
    flushW = 1'b1;
    exp_q.delete();
    step();
    flushW = 1'b0;
    idle_in();
    chk("flush_count",    64'(count), 64'd0);
    chk("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("flush_retired",  retired, 64'd3);

    // Full queue: dequeue plus refused enqueue, then 10 cycles of streaming
    offer(mk(64'h0000_0000_8000_0060, 1'b1), 1'b0, 1'b1);
    step();
    offer(mk(64'h0000_0000_8000_0070, 1'b0), 1'b0, 1'b1);
    step();
    offer(mk(64'h0000_0000_8000_0080, 1'b0), 1'b0, 1'b0);
    bus.wb_ready = 1'b1;
    chk("full_refuse_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("full_deq_count", 64'(count), 64'd1);
    for (int i = 0; i < 10; i++) begin
      offer(mk(64'h0000_0000_9000_0000 + 64'(i * 4), i[0]), 1'b0, 1'b1);
      step();
      chk("stream_count", 64'(count), 64'd1);
    end
    idle_in();
    step();
    chk("stream_drained", 64'(count), 64'd0);
    chk("stream_retired", retired, 64'd15);
    bus.wb_ready = 1'b0;

    // Asynchronous reset in mid-cycle with two entries buffered
    offer(mk(64'h0000_0000_A000_0000, 1'b0), 1'b0, 1'b1);
    step();
    offer(mk(64'h0000_0000_A000_0004, 1'b0), 1'b0, 1'b1);
    step();
    idle_in();
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("async_rst_count",    64'(count), 64'd0);
    chk("async_rst_retired",  retired, 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
